// File: rtl/sample_packer_64_pkg.sv
// Shared constants and the word+count bundle used by the packer and the
// averaging-side unpacker.
package sample_packer_64_pkg;
    localparam int SAMPLE_W = 8;
    localparam int LANES    = 8;
    localparam int WORD_W   = SAMPLE_W * LANES;
    localparam int CNT_W    = 4;
    localparam int K_W      = $clog2(LANES);

    typedef struct packed {
        logic [CNT_W-1:0]  count;
        logic [WORD_W-1:0] data;
    } packed_word_t;
endpackage

// File: rtl/packer_out_slot.sv
// Output register of the packer: holds a finished word until downstream
// accepts it and reports whether a new word may be loaded this cycle.
module packer_out_slot
    import sample_packer_64_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    output logic              slot_free
);
    packed_word_t word_reg;
    logic         valid_reg;
    logic         valid_next;

    // A transfer and a load on the same edge keep valid high (back-to-back).
    always_comb begin
        valid_next = valid_reg;
        if (load) begin
            valid_next = 1'b1;
        end else if (out_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            if (load) begin
                word_reg <= '{count: load_count, data: load_data};
            end
        end
    end

    assign slot_free = !valid_reg || out_ready;
    assign out_data  = word_reg.data;
    assign out_count = word_reg.count;
    assign out_valid = valid_reg;
endmodule

// File: rtl/sample_packer_64.sv
// Packs a valid/ready stream of bytes into 64-bit words with a sample count;
// flush emits whatever partial word has been assembled.
module sample_packer_64
    import sample_packer_64_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count
);
    localparam logic [K_W-1:0] K_LAST = K_W'(LANES - 1);

    logic [WORD_W-1:0] asm_reg, asm_next, asm_with;
    logic [K_W-1:0]    k_reg, k_next;
    logic              pend_reg, pend_next;
    logic [CNT_W-1:0]  k_with;
    logic              beat;
    logic              slot_free;
    logic              load;

    // in_ready depends combinationally on out_ready through slot_free.
    assign in_ready = !rst && !pend_reg && !(k_reg == K_LAST && !slot_free);
    assign beat     = in_valid && in_ready;
    assign k_with   = CNT_W'(k_reg) + CNT_W'(beat);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign asm_with[gi*SAMPLE_W +: SAMPLE_W] =
                (beat && k_reg == K_W'(gi)) ? in_data : asm_reg[gi*SAMPLE_W +: SAMPLE_W];
        end
    endgenerate

    // A beat is merged before flushing, so flush+beat at k==7 is one full word.
    assign load = slot_free &&
                  ((beat && k_reg == K_LAST) || ((flush || pend_reg) && k_with != '0));

    always_comb begin
        asm_next  = asm_with;
        k_next    = k_with[K_W-1:0];
        pend_next = pend_reg || (flush && k_with != '0);
        if (load) begin
            asm_next  = '0;
            k_next    = '0;
            pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_reg  <= '0;
            k_reg    <= '0;
            pend_reg <= 1'b0;
        end else begin
            asm_reg  <= asm_next;
            k_reg    <= k_next;
            pend_reg <= pend_next;
        end
    end

    packer_out_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (asm_with),
        .load_count (k_with),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .slot_free  (slot_free)
    );
endmodule

// File: tb/tb_sample_packer_64.sv
// Directed bench for sample_packer_64: full words, stalls, flush cases and
// asynchronous reset, one line per transaction.
module tb_sample_packer_64;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_packer_64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || out_count !== 4'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h count=%0d in_ready=%b, want 0/0/0/0",
                     out_valid, out_data, out_count, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
        $display("reset: valid=%b count=%0d in_ready=%b", out_valid, out_count, in_ready);
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(i + 1); in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== (i == 7)) begin
                errors++;
                $display("FAIL full_valid_timing: beat %0d out_valid=%b want %b", i, out_valid, (i == 7));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_data !== 64'h0807060504030201 || out_count !== 4'd8) begin
            errors++;
            $display("FAIL full_word: data=%h count=%0d want 0807060504030201/8", out_data, out_count);
        end
        $display("full_word: data=%h count=%0d", out_data, out_count);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_single_cycle: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int idx = 0; idx < 15; idx++) begin
            in_data = 8'(8'h10 + idx); in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_ready: byte %0d in_ready=%b want 1", idx, in_ready);
            end
            tick();
            if (idx >= 7) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 64'h1716151413121110 || out_count !== 4'd8) begin
                    errors++;
                    $display("FAIL stall_hold: byte %0d valid=%b data=%h count=%0d want 1/1716151413121110/8",
                             idx, out_valid, out_data, out_count);
                end
            end
        end
        in_data = 8'h1F; in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_data !== 64'h1716151413121110) begin
                errors++;
                $display("FAIL stall_full_block: in_ready=%b data=%h want 0/1716151413121110", in_ready, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h1F1E1D1C1B1A1918 || out_count !== 4'd8) begin
            errors++;
            $display("FAIL back_to_back: valid=%b data=%h count=%0d want 1/1F1E1D1C1B1A1918/8",
                     out_valid, out_data, out_count);
        end
        $display("back_to_back: data=%h count=%0d", out_data, out_count);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush_partial();
        out_ready = 1'b1;
        send(8'hAA); send(8'hBB); send(8'hCC);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL partial_no_early: out_valid=%b want 0", out_valid);
        end
        flush = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h0000000000CCBBAA || out_count !== 4'd3) begin
            errors++;
            $display("FAIL flush_partial: valid=%b data=%h count=%0d want 1/0000000000CCBBAA/3",
                     out_valid, out_data, out_count);
        end
        $display("flush_partial: data=%h count=%0d", out_data, out_count);
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: out_valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty_after: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush_with_beat();
        out_ready = 1'b1;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        flush = 1'b1;
        send(8'h05);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h0000000504030201 || out_count !== 4'd5) begin
            errors++;
            $display("FAIL flush_with_beat: valid=%b data=%h count=%0d want 1/0000000504030201/5",
                     out_valid, out_data, out_count);
        end
        $display("flush_with_beat: data=%h count=%0d", out_data, out_count);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_beat_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush_stalled();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h31 + i));
        send(8'h41); send(8'h42);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_data = 8'h43; in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'h3837363534333231) begin
                errors++;
                $display("FAIL flush_pending_hold: in_ready=%b valid=%b data=%h want 0/1/3837363534333231",
                         in_ready, out_valid, out_data);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h0000000000004241 || out_count !== 4'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_pending_done: valid=%b data=%h count=%0d in_ready=%b want 1/0000000000004241/2/1",
                     out_valid, out_data, out_count, in_ready);
        end
        $display("flush_stalled: data=%h count=%0d", out_data, out_count);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_pending_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h51 + i));
        for (int i = 0; i < 4; i++) send(8'(8'h61 + i));
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || out_count !== 4'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h count=%0d in_ready=%b want 0/0/0/0",
                     out_valid, out_data, out_count, in_ready);
        end
        $display("async_reset: valid=%b data=%h", out_valid, out_data);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h21 + i); in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== (i == 7)) begin
                errors++;
                $display("FAIL post_reset_timing: beat %0d out_valid=%b want %b", i, out_valid, (i == 7));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_data !== 64'h2827262524232221 || out_count !== 4'd8) begin
            errors++;
            $display("FAIL post_reset_word: data=%h count=%0d want 2827262524232221/8", out_data, out_count);
        end
        $display("post_reset_word: data=%h count=%0d", out_data, out_count);
        tick();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_flush_partial();
        test_flush_with_beat();
        test_flush_stalled();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
